sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
// - Shares the single-ported data SRAM (sram_if read + masked-write port) between two requesters:
//   instruction fetch (IF, read-only) and memory access stage (MEM, load/store).
// - Same-cycle grant with fixed MEM priority plus an anti-starvation override for IF.
// - Tracks the owner of each 1-cycle-latency read and routes the returned data to that owner.
// - Sits between the IF/MEM stages and the SRAM; a low grant is the requester's stall.
// PARAMETERS
// - ADDR_W      32  address width (`ADDR_WIDTH)
// - DATA_W      32  data width (`DATA_WIDTH)
// - NBYTES      4   byte lanes = DATA_W/8 (`NUM_OF_BYTES)
// - STARVE_MAX  4   consecutive denied IF cycles before IF is forced to win; range 1..15
// PORTS
// - clk            in   1       clock; single clock domain
// - rst_n          in   1       async active-low reset
// - if_req         in   1       IF read request; if_addr held stable until if_gnt
// - if_addr        in   ADDR_W  IF read address, word aligned
// - if_gnt         out  1       IF request accepted this cycle
// - if_rvalid      out  1       IF read data valid (one-cycle pulse)
// - if_rdata       out  DATA_W  IF read data
// - if_flush       in   1       discard any in-flight IF read response
// - mem_req        in   1       MEM request; all mem_* fields held stable until mem_gnt
// - mem_we         in   1       1 = store, 0 = load
// - mem_addr       in   ADDR_W  word-aligned address
// - mem_wdata      in   DATA_W  lane-aligned store data
// - mem_wmask      in   NBYTES  store byte mask
// - mem_gnt        out  1       MEM request accepted this cycle
// - mem_rvalid     out  1       MEM load data valid (one-cycle pulse)
// - mem_rdata      out  DATA_W  MEM load data
// - sram_rd_en     out  1       SRAM read strobe
// - sram_rd_addr   out  ADDR_W  SRAM read address
// - sram_rd_data   in   DATA_W  SRAM read data, valid the cycle after sram_rd_en
// - sram_wr_en     out  1       SRAM write strobe
// - sram_wr_addr   out  ADDR_W  SRAM write address
// - sram_wr_data   out  DATA_W  SRAM write data
// - sram_wr_mask   out  NBYTES  SRAM byte mask
// BEHAVIOUR
// - Reset: owner=IDLE, starve_cnt=0; all gnt/rvalid/sram enables 0, rdata 0, addr/data/mask 0.
// - At most one access issued per cycle. Grant is combinational on req, registered state only.
// - Arbitration: only one requester -> it wins; both -> MEM wins unless starve_cnt==STARVE_MAX,
//   in which case IF wins.
// - starve_cnt: +1 (saturating at STARVE_MAX) when if_req && !if_gnt; cleared on if_gnt or !if_req.
// - Issue: IF grant -> sram_rd_en=1, rd_addr=if_addr. MEM load grant -> sram_rd_en=1, rd_addr=mem_addr.
//   MEM store grant -> sram_wr_en=(mem_wmask!=0), wr_addr/wr_data/wr_mask pass through; store done at grant.
// - Owner FSM (read in flight), next state from this cycle's grant:
//   IDLE -> RD_IF on IF grant, -> RD_MEM on MEM load grant, else stays IDLE.
//   RD_IF/RD_MEM -> (same rules); a new grant is allowed in the response cycle (back-to-back, 1 req/cycle).
// - Response: in RD_MEM, mem_rvalid=1, mem_rdata=sram_rd_data. In RD_IF, if_rvalid=1,
//   if_rdata=sram_rd_data, unless killed. Non-owner rdata outputs 0.
// - if_flush: kills the in-flight IF response (if_rvalid 0 in the response cycle) when asserted in the
//   grant cycle or the response cycle; also forces if_gnt=0 in that cycle. No effect on MEM.
// - Store while an IF read is in flight: allowed; store and read response coexist in one cycle.
// - Reset mid-operation: in-flight response dropped, no rvalid after rst_n rises.
// - Disabled read/write strobes keep address/data outputs at 0 (no X propagation).
// STRUCTURE
// - Shared package sram_arb_pkg: typedef enum logic [1:0] {OWN_IDLE, OWN_IF, OWN_MEM} owner_e;
//   localparam STARVE_W = $clog2(STARVE_MAX+1).
// - One sub-module: sram_arb_starve_ctr (saturating counter, inc/clr/sat ports).
// - Top: combinational grant/issue mux + owner register + response routing.
// TESTING
// - IF only, addr 0x100 held 3 cycles -> if_gnt all 3 cycles; if_rvalid each following cycle with SRAM words.
// - IF+MEM load 0x200 same cycle -> mem_gnt=1, if_gnt=0; next cycle mem_rvalid, mem_rdata=word@0x200.
// - MEM store 0x40 data 0x0000AB00 mask 0010 -> sram_wr_en=1, wr_mask=0010, no rvalid; mask 0000 -> sram_wr_en=0, mem_gnt=1.
// - MEM req held 6 cycles with IF req, STARVE_MAX=4 -> IF denied 4 cycles, granted 5th, MEM resumes 6th.
// - IF granted at 0x300, if_flush next cycle -> if_rvalid stays 0; if_flush=1 with if_req -> if_gnt=0.
// - rst_n low in response cycle of MEM load -> mem_rvalid 0, all outputs 0; after release idle, counter 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and sizing for the SRAM port arbiter.
package sram_arb_pkg;

    // Which requester owns the read whose data returns this cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    // Largest legal starvation limit.
    localparam int STARVE_MAX_LIMIT = 15;

    // Counter width, sized for the top of the legal range so any chosen limit fits.
    localparam int STARVE_W = $clog2(STARVE_MAX_LIMIT + 1);

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Saturating counter of consecutive cycles in which IF asked for the SRAM
// and was refused. sat tells the arbiter to let IF win next time.
module sram_arb_starve_ctr
    import sram_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [STARVE_W-1:0] cnt_r;

    assign sat = (cnt_r == STARVE_W'(MAX));

    // Count refused IF cycles; clear wins over increment; hold at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {STARVE_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {STARVE_W{1'b0}};
        end else if (inc && !sat) begin
            cnt_r <= cnt_r + STARVE_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-ported data SRAM between instruction fetch (read only)
// and the memory stage (load/store). MEM has fixed priority; IF is forced
// through after STARVE_MAX refused cycles. Grants are combinational and a low
// grant is the requester's stall. The owner of each one-cycle read is
// remembered so the returning data goes to the right requester.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NBYTES     = DATA_W / 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              if_flush,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [NBYTES-1:0] mem_wmask,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic [NBYTES-1:0] sram_wr_mask
);

    owner_e owner_r;
    owner_e owner_next_s;
    logic   if_eligible_s;
    logic   starve_sat_s;
    logic   starve_inc_s;

    // A flush cancels IF's claim on the port for this cycle.
    assign if_eligible_s = if_req && !if_flush;
    assign starve_inc_s  = if_req && !if_gnt;

    sram_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc_s),
        .clr   (!starve_inc_s),
        .sat   (starve_sat_s)
    );

    // Grant: MEM first, unless a starved IF is waiting.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (mem_req && !(if_eligible_s && starve_sat_s)) begin
            mem_gnt = 1'b1;
        end else if (if_eligible_s) begin
            if_gnt = 1'b1;
        end else begin
            if_gnt  = 1'b0;
            mem_gnt = 1'b0;
        end
    end

    // Issue the granted access; idle strobes keep address/data at zero.
    always_comb begin
        sram_rd_en   = 1'b0;
        sram_rd_addr = {ADDR_W{1'b0}};
        sram_wr_en   = 1'b0;
        sram_wr_addr = {ADDR_W{1'b0}};
        sram_wr_data = {DATA_W{1'b0}};
        sram_wr_mask = {NBYTES{1'b0}};
        if (if_gnt) begin
            sram_rd_en   = 1'b1;
            sram_rd_addr = if_addr;
        end else if (mem_gnt && !mem_we) begin
            sram_rd_en   = 1'b1;
            sram_rd_addr = mem_addr;
        end else if (mem_gnt && mem_we && (mem_wmask != {NBYTES{1'b0}})) begin
            sram_wr_en   = 1'b1;
            sram_wr_addr = mem_addr;
            sram_wr_data = mem_wdata;
            sram_wr_mask = mem_wmask;
        end else begin
            sram_rd_en = 1'b0;
            sram_wr_en = 1'b0;
        end
    end

    // Next owner follows this cycle's read grant; a store leaves nothing in flight.
    always_comb begin
        owner_next_s = OWN_IDLE;
        if (if_gnt) begin
            owner_next_s = OWN_IF;
        end else if (mem_gnt && !mem_we) begin
            owner_next_s = OWN_MEM;
        end else begin
            owner_next_s = OWN_IDLE;
        end
    end

    // Owner register; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= OWN_IDLE;
        end else begin
            owner_r <= owner_next_s;
        end
    end

    // Route returning read data to its owner; a flush kills an IF response.
    always_comb begin
        if_rvalid  = 1'b0;
        if_rdata   = {DATA_W{1'b0}};
        mem_rvalid = 1'b0;
        mem_rdata  = {DATA_W{1'b0}};
        case (owner_r)
            OWN_IF: begin
                if (!if_flush) begin
                    if_rvalid = 1'b1;
                    if_rdata  = sram_rd_data;
                end else begin
                    if_rvalid = 1'b0;
                end
            end
            OWN_MEM: begin
                mem_rvalid = 1'b1;
                mem_rdata  = sram_rd_data;
            end
            default: begin
                if_rvalid  = 1'b0;
                mem_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Grants and SRAM strobes are checked
// directly each cycle; read responses are predicted into a queue when the
// read is granted and checked by an independent monitor when rvalid shows.
// SRAM initial contents: word at byte address a = {16'hC0DE, a[15:0]}.
module tb_sram_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int NBYTES     = 4;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_flush;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NBYTES-1:0] mem_wmask;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              sram_rd_en;
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [DATA_W-1:0] sram_rd_data = 32'h0000_0000;
    logic              sram_wr_en;
    logic [ADDR_W-1:0] sram_wr_addr;
    logic [DATA_W-1:0] sram_wr_data;
    logic [NBYTES-1:0] sram_wr_mask;

    logic [31:0] sram_mem [0:255];

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
        logic [31:0] due;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    sram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NBYTES     (NBYTES),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_flush     (if_flush),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .sram_wr_en   (sram_wr_en),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .sram_wr_mask (sram_wr_mask)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected responses.
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one-cycle read latency, byte-masked write.
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= sram_mem[sram_rd_addr[9:2]];
        if (sram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wr_mask[b]) sram_mem[sram_wr_addr[9:2]][8*b +: 8] = sram_wr_data[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input logic is_if, input logic [31:0] data);
        rsp_t e;
        e.is_if = is_if;
        e.data  = data;
        e.due   = 32'(cyc + 1);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the clock edge, then wait to mid-cycle.
    task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                        input logic mr, input logic mw, input logic [31:0] ma,
                        input logic [31:0] wd, input logic [3:0] wm);
        @(posedge clk);
        #1;
        if_req    = ir;
        if_addr   = ia;
        if_flush  = fl;
        mem_req   = mr;
        mem_we    = mw;
        mem_addr  = ma;
        mem_wdata = wd;
        mem_wmask = wm;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_if_gnt"},       {31'h0, if_gnt},       32'h0);
        check({tag, "_mem_gnt"},      {31'h0, mem_gnt},      32'h0);
        check({tag, "_if_rvalid"},    {31'h0, if_rvalid},    32'h0);
        check({tag, "_mem_rvalid"},   {31'h0, mem_rvalid},   32'h0);
        check({tag, "_if_rdata"},     if_rdata,              32'h0);
        check({tag, "_mem_rdata"},    mem_rdata,             32'h0);
        check({tag, "_rd_en"},        {31'h0, sram_rd_en},   32'h0);
        check({tag, "_rd_addr"},      sram_rd_addr,          32'h0);
        check({tag, "_wr_en"},        {31'h0, sram_wr_en},   32'h0);
        check({tag, "_wr_addr"},      sram_wr_addr,          32'h0);
        check({tag, "_wr_data"},      sram_wr_data,          32'h0);
        check({tag, "_wr_mask"},      {28'h0, sram_wr_mask}, 32'h0);
    endtask

    task automatic chk_gnt(input string tag, input logic exp_if, input logic exp_mem);
        check({tag, "_if_gnt"},  {31'h0, if_gnt},  {31'h0, exp_if});
        check({tag, "_mem_gnt"}, {31'h0, mem_gnt}, {31'h0, exp_mem});
    endtask

    // Response monitor: every rvalid must match the oldest prediction in its cycle.
    always @(negedge clk) begin
        rsp_t e;
        if (if_rvalid && mem_rvalid) begin
            checks++;
            errors++;
            $display("FAIL both_rvalid: got if_rvalid=1 mem_rvalid=1 expected at most one (cycle %0d)", cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (if_rvalid || mem_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got if_rvalid=%0b mem_rvalid=%0b expected none (cycle %0d)",
                         if_rvalid, mem_rvalid, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_cycle", 32'(cyc), e.due);
                check("rsp_owner_is_if", {31'h0, if_rvalid}, {31'h0, e.is_if});
                check("rsp_data", if_rvalid ? if_rdata : mem_rdata, e.data);
                check("rsp_nonowner_rdata", if_rvalid ? mem_rdata : if_rdata, 32'h0);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= 32'(cyc)) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rvalid: got no rvalid expected data 0x%08h is_if=%0b (cycle %0d)",
                     e.data, e.is_if, cyc);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 32'hC0DE_0000 | 32'(i * 4);
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wmask = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // IF alone, same address held three cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            chk_gnt("if_only", 1'b1, 1'b0);
            check("if_only_rd_en", {31'h0, sram_rd_en}, 32'h1);
            check("if_only_rd_addr", sram_rd_addr, 32'h100);
            expect_rsp(1'b1, 32'hC0DE_0100);
        end
        idle();

        // Both request: MEM load wins, IF goes next cycle back-to-back.
        step(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        chk_gnt("both", 1'b0, 1'b1);
        check("both_rd_addr", sram_rd_addr, 32'h200);
        expect_rsp(1'b0, 32'hC0DE_0200);
        step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_gnt("if_after_mem", 1'b1, 1'b0);
        expect_rsp(1'b1, 32'hC0DE_0104);
        idle();

        // Stores: byte-masked write, then an empty mask which must not strobe.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0000_AB00, 4'b0010);
        chk_gnt("store", 1'b0, 1'b1);
        check("store_wr_en", {31'h0, sram_wr_en}, 32'h1);
        check("store_wr_mask", {28'h0, sram_wr_mask}, 32'h2);
        check("store_wr_addr", sram_wr_addr, 32'h40);
        check("store_wr_data", sram_wr_data, 32'h0000_AB00);
        check("store_rd_en", {31'h0, sram_rd_en}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 4'b0000);
        chk_gnt("store_nomask", 1'b0, 1'b1);
        check("store_nomask_wr_en", {31'h0, sram_wr_en}, 32'h0);
        check("store_nomask_wr_data", sram_wr_data, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        expect_rsp(1'b0, 32'hC0DE_AB40);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        expect_rsp(1'b0, 32'hC0DE_0044);

        // Store issued while an IF read is returning.
        step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expect_rsp(1'b1, 32'hC0DE_0108);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h48, 32'h1234_5678, 4'hF);
        chk_gnt("store_inflight", 1'b0, 1'b1);
        check("store_inflight_wr_en", {31'h0, sram_wr_en}, 32'h1);
        check("store_inflight_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0);
        expect_rsp(1'b0, 32'h1234_5678);
        idle();

        // Starvation: IF refused four cycles, wins the fifth, MEM back on the sixth.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i == 5) ? 32'h110 : 32'h10C, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
            chk_gnt("starve", i == 4, i != 4);
            if (i == 4) expect_rsp(1'b1, 32'hC0DE_010C);
            else        expect_rsp(1'b0, 32'hC0DE_0080);
        end
        idle();

        // Flush: kills the response after a grant, and blocks a grant while high.
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_gnt("flush_grant", 1'b1, 1'b0);
        check("flush_grant_rd_addr", sram_rd_addr, 32'h300);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("flush_killed_rvalid", {31'h0, if_rvalid}, 32'h0);
        check("flush_killed_rdata", if_rdata, 32'h0);
        step(1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk_gnt("flush_req", 1'b0, 1'b0);
        check("flush_req_rd_en", {31'h0, sram_rd_en}, 32'h0);
        idle();
        check("flush_after_rvalid", {31'h0, if_rvalid}, 32'h0);

        // Build up IF starvation, then reset in the response cycle of a MEM load.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h114, 1'b0, 1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
            chk_gnt("prereset", 1'b0, 1'b1);
            expect_rsp(1'b0, 32'hC0DE_0084);
        end
        step(1'b1, 32'h114, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        chk_gnt("prereset_load", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; if_addr = 32'h0; mem_addr = 32'h0;
        @(negedge clk);
        chk_all_zero("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("postreset");

        // Counter must have restarted: four more MEM wins before IF gets through.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h114, 1'b0, 1'b1, 1'b0, 32'h88, 32'h0, 4'h0);
            chk_gnt("postreset_starve", i == 4, i != 4);
            if (i == 4) expect_rsp(1'b1, 32'hC0DE_0114);
            else        expect_rsp(1'b0, 32'hC0DE_0088);
        end
        idle();
        idle();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
